cache_bus_arbiter: RTL and testbench
====================================

CACHE_BUS_ARBITER -- requirements
Module: cache_bus_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 8: consecutive lost-arbitration cycles before inst port gets priority (range 1..255).
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  single clock; all state on posedge clk.
- rst  in  1  asynchronous, active-high reset.
- inst_req / inst_wr  in  1 / 1  ICache request, write flag.
- inst_size / inst_addr / inst_wdata  in  2 / 32 / 32  ICache size, address, write data.
- inst_rdata / inst_addr_ok / inst_data_ok  out  32 / 1 / 1  ICache read data, address and data handshakes.
- data_req / data_wr / data_size / data_addr / data_wdata  in  1/1/2/32/32  DataCache request fields.
- data_rdata / data_addr_ok / data_data_ok  out  32 / 1 / 1  DataCache responses.
- bus_req / bus_wr / bus_size / bus_addr / bus_wdata  out  1/1/2/32/32  shared SRAM-like request toward AXI bridge.
- bus_rdata / bus_addr_ok / bus_data_ok  in  32 / 1 / 1  bridge responses.

Function
REQ-003 SHALL implement FSM states IDLE, WAIT_I, WAIT_D; reset state IDLE.
REQ-004 SHALL, in IDLE, select one granted port combinationally and drive its req/wr/size/addr/wdata onto bus_*; zero added cycles on address path.
REQ-005 SHALL grant data port when both request, unless inst priority flag set (REQ-010/REQ-014).
REQ-006 SHALL assert granted port's addr_ok = bus_addr_ok in IDLE; ungranted port addr_ok = 0.
REQ-007 SHALL lock grant: if bus_req=1 and bus_addr_ok=0, same port stays granted next cycle regardless of other requests, until its handshake.
REQ-008 SHALL on bus_req & bus_addr_ok in IDLE go to WAIT_I or WAIT_D per owner; in WAIT_* bus_req=0 and both addr_ok=0 (one outstanding transaction).
REQ-009 SHALL in WAIT_x drive owner data_ok = bus_data_ok, other data_ok = 0; both rdata = bus_rdata; on bus_data_ok return to IDLE; next address accepted no earlier than cycle after data_ok.
REQ-010 SHALL keep 8-bit starve counter: +1 (saturating) each IDLE cycle with inst_req=1 and data granted; cleared on inst address handshake; inst priority flag = (counter >= STARVE_LIMIT).
REQ-011 SHALL ignore bus_data_ok while in IDLE (no data_ok to either port).
REQ-012 SHALL drive bus_req=0 when neither port requests in IDLE; bus_* data fields then don't-care but SHALL be the data port's fields.

Reset
REQ-013 SHALL on rst asynchronously force: state IDLE, grant lock cleared, starve counter 0, priority flag 0; outputs bus_req, inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok = 0 while rst=1; transaction in flight at reset discarded, its late bus_data_ok ignored per REQ-011.

Configuration
REQ-014 SHALL support macro CACHE_ARB_ROUND_ROBIN_EN: defined -> 1-bit last-served register (reset to inst), priority goes to port not served last on each address handshake, starve counter and STARVE_LIMIT unused; undefined -> fixed data priority with starve counter per REQ-010.

Verification
REQ-015 Both req=1 at same cycle, bus_addr_ok=1 -> data_addr_ok=1, inst_addr_ok=0, state WAIT_D; data_data_ok follows bus_data_ok 3 cycles later, bus_rdata=0xDEADBEEF seen on data_rdata.
REQ-016 inst_req=1, bus_addr_ok=0 for 4 cycles, data_req rises cycle 2 -> bus_addr stays inst_addr until inst_addr_ok; data granted only after inst data_ok.
REQ-017 Undefined macro, STARVE_LIMIT=3, data_req and inst_req held high, 1-cycle bus responses -> inst granted after 3 lost IDLE cycles, counter back to 0.
REQ-018 CACHE_ARB_ROUND_ROBIN_EN defined, both held high -> grants alternate D,I,D,I after reset-first grant to data.
REQ-019 rst pulsed while WAIT_I, then bus_data_ok=1 in IDLE -> inst_data_ok=0, data_data_ok=0, state IDLE, bus_req reflects new requests next cycle.

Source files
------------

// File: rtl/cache_bus_arbiter.sv
// Arbitrates ICache/DCache SRAM-like requests onto one bus; one outstanding transaction, 0-cycle address path.
// Optional macro CACHE_ARB_ROUND_ROBIN_EN replaces data-priority + starve counter with round-robin priority.
module cache_bus_arbiter #(
   parameter int STARVE_LIMIT = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        inst_req,
   input  logic        inst_wr,
   input  logic [1:0]  inst_size,
   input  logic [31:0] inst_addr,
   input  logic [31:0] inst_wdata,
   output logic [31:0] inst_rdata,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic [31:0] data_rdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic        bus_req,
   output logic        bus_wr,
   output logic [1:0]  bus_size,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata,
   input  logic        bus_addr_ok,
   input  logic        bus_data_ok
);

   typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D} state_t;

   state_t state, state_nxt;
   logic   lock_vld, lock_inst;
   logic   grant_inst, inst_pri, hs;

   assign hs = bus_req & bus_addr_ok;

`ifdef CACHE_ARB_ROUND_ROBIN_EN
   logic last_inst;

   assign inst_pri = ~last_inst;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         last_inst <= 1'b1;
      else if (state == IDLE && hs)
         last_inst <= grant_inst;
   end
`else
   localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);
   logic [7:0] starve_cnt;

   assign inst_pri = (starve_cnt >= LIMIT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         starve_cnt <= 8'd0;
      else if (state == IDLE) begin
         if (hs && grant_inst)
            starve_cnt <= 8'd0;
         else if (inst_req && !grant_inst && starve_cnt != 8'hff)
            starve_cnt <= starve_cnt + 8'd1;
      end
   end
`endif

   // A port that was presented but not accepted keeps the bus until its handshake.
   always_comb begin
      grant_inst = 1'b0;
      if (lock_vld && (lock_inst ? inst_req : data_req))
         grant_inst = lock_inst;
      else if (inst_req && data_req)
         grant_inst = inst_pri;
      else
         grant_inst = inst_req;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lock_vld  <= 1'b0;
         lock_inst <= 1'b0;
      end else if (state == IDLE) begin
         lock_vld  <= bus_req & ~bus_addr_ok;
         lock_inst <= grant_inst;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (hs) state_nxt = grant_inst ? WAIT_I : WAIT_D;
         WAIT_I,
         WAIT_D:  if (bus_data_ok) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus_req      = ~rst & (state == IDLE) & (grant_inst ? inst_req : data_req);
      bus_wr       = grant_inst ? inst_wr    : data_wr;
      bus_size     = grant_inst ? inst_size  : data_size;
      bus_addr     = grant_inst ? inst_addr  : data_addr;
      bus_wdata    = grant_inst ? inst_wdata : data_wdata;
      inst_addr_ok = bus_req & bus_addr_ok & grant_inst;
      data_addr_ok = bus_req & bus_addr_ok & ~grant_inst;
      inst_data_ok = ~rst & (state == WAIT_I) & bus_data_ok;
      data_data_ok = ~rst & (state == WAIT_D) & bus_data_ok;
      inst_rdata   = bus_rdata;
      data_rdata   = bus_rdata;
   end

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized traffic against a rule-level model.
module tb_cache_bus_arbiter;

   localparam int LIM = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_req, inst_wr, data_req, data_wr;
   logic [1:0]  inst_size, data_size;
   logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
   logic [31:0] inst_rdata, data_rdata;
   logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
   logic        bus_req, bus_wr;
   logic [1:0]  bus_size;
   logic [31:0] bus_addr, bus_wdata, bus_rdata;
   logic        bus_addr_ok, bus_data_ok;

   int n_cmp = 0;
   int n_bad = 0;

   cache_bus_arbiter #(.STARVE_LIMIT(LIM)) dut (
      .clk(clk), .rst(rst),
      .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
      .inst_addr(inst_addr), .inst_wdata(inst_wdata),
      .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_addr(data_addr), .data_wdata(data_wdata),
      .data_rdata(data_rdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
      .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_rdata(bus_rdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok)
   );

   always #5 clk = ~clk;

   // Rule-level model: is a transaction outstanding and whose, who was left hanging, how long inst has lost.
   bit m_busy, m_own_i, m_lock_v, m_lock_i;
   int m_lost;
   bit e_breq, e_iaok, e_daok, e_idok, e_ddok, e_win_i;

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_eval();
      {e_breq, e_iaok, e_daok, e_idok, e_ddok, e_win_i} = '0;
      if (rst) begin
      end else if (m_busy) begin
         e_idok = m_own_i & bus_data_ok;
         e_ddok = ~m_own_i & bus_data_ok;
      end else begin
         if (m_lock_v && (m_lock_i ? inst_req : data_req)) e_win_i = m_lock_i;
         else if (inst_req && data_req)                    e_win_i = (m_lost >= LIM);
         else                                              e_win_i = inst_req;
         e_breq = e_win_i ? inst_req : data_req;
         e_iaok = e_breq & bus_addr_ok & e_win_i;
         e_daok = e_breq & bus_addr_ok & ~e_win_i;
      end
   endtask

   task automatic model_update();
      if (rst) begin
         m_busy = 0; m_lock_v = 0; m_lock_i = 0; m_lost = 0;
      end else if (m_busy) begin
         if (bus_data_ok) m_busy = 0;
      end else begin
         if (e_breq && bus_addr_ok) begin
            m_busy = 1; m_own_i = e_win_i; m_lock_v = 0;
         end else begin
            m_lock_v = e_breq; m_lock_i = e_win_i;
         end
         if (e_win_i && e_breq && bus_addr_ok) m_lost = 0;
         else if (!e_win_i && inst_req)        m_lost = (m_lost < 255) ? m_lost + 1 : 255;
      end
   endtask

   task automatic settle();
      #1;
      model_eval();
      check("ctrl", {bus_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok},
                    {e_breq, e_iaok, e_daok, e_idok, e_ddok});
      check("rdata", {inst_rdata, data_rdata}, {bus_rdata, bus_rdata});
      if (!rst && !m_busy)
         check("fields", {bus_wr, bus_size, bus_addr, bus_wdata},
               e_win_i ? {inst_wr, inst_size, inst_addr, inst_wdata}
                       : {data_wr, data_size, data_addr, data_wdata});
   endtask

   task automatic advance();
      model_update();
      @(negedge clk);
   endtask

   initial begin
      rst = 1; inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wdata = 0;
      data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
      bus_rdata = 0; bus_addr_ok = 0; bus_data_ok = 0;
      m_busy = 0; m_own_i = 0; m_lock_v = 0; m_lock_i = 0; m_lost = 0;
      @(negedge clk);

      // Reset holds every handshake low even with live requests
      inst_req = 1; data_req = 1; bus_addr_ok = 1; bus_data_ok = 1;
      settle();
      check("reset_ctrl", {bus_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 5'b0);
      advance();

      // Simultaneous requests: data wins, response 3 cycles later
      rst = 0; bus_data_ok = 0;
      inst_addr = 32'h0000_1000; data_addr = 32'h0000_2000; data_wr = 1; data_size = 2; data_wdata = 32'h55;
      settle();
      check("both_daok", data_addr_ok, 1'b1);
      check("both_iaok", inst_addr_ok, 1'b0);
      check("both_addr", bus_addr, 32'h0000_2000);
      advance();
      inst_req = 0; data_req = 0; bus_addr_ok = 0;
      for (int k = 1; k <= 3; k++) begin
         bus_data_ok = (k == 3);
         bus_rdata   = (k == 3) ? 32'hDEAD_BEEF : 32'h0;
         settle();
         check("waitd_breq", bus_req, 1'b0);
         check("waitd_ddok", data_data_ok, (k == 3) ? 1'b1 : 1'b0);
         if (k == 3) begin
            check("waitd_rdata", data_rdata, 32'hDEAD_BEEF);
            check("waitd_idok", inst_data_ok, 1'b0);
         end
         advance();
      end
      bus_data_ok = 0;

      // Inst stalled on address; data arriving later cannot steal the bus
      inst_req = 1; inst_addr = 32'h0000_3000; data_addr = 32'h0000_4000;
      for (int k = 0; k < 5; k++) begin
         data_req    = (k >= 1);
         bus_addr_ok = (k == 4);
         settle();
         check("lock_addr", bus_addr, 32'h0000_3000);
         check("lock_iaok", inst_addr_ok, (k == 4) ? 1'b1 : 1'b0);
         check("lock_daok", data_addr_ok, 1'b0);
         advance();
      end
      inst_req = 0;
      for (int k = 0; k < 3; k++) begin
         bus_data_ok = (k == 2);
         settle();
         check("waiti_daok", data_addr_ok, 1'b0);
         check("waiti_idok", inst_data_ok, (k == 2) ? 1'b1 : 1'b0);
         advance();
      end
      bus_data_ok = 0;
      settle();
      check("after_daok", data_addr_ok, 1'b1);
      check("after_addr", bus_addr, 32'h0000_4000);
      advance();
      data_req = 0; bus_addr_ok = 0; bus_data_ok = 1;
      settle();
      advance();

      // Starvation: with limit 3, grants go D,D,D,I repeatedly
      rst = 1; bus_data_ok = 0;
      settle();
      advance();
      rst = 0; inst_req = 1; data_req = 1; bus_addr_ok = 1; bus_data_ok = 1;
      for (int c = 0; c < 16; c++) begin
         settle();
         if (c % 2 == 0) begin
            check("starve_iaok", inst_addr_ok, ((c / 2) % 4 == 3) ? 1'b1 : 1'b0);
            check("starve_daok", data_addr_ok, ((c / 2) % 4 == 3) ? 1'b0 : 1'b1);
            check("idle_dok", {inst_data_ok, data_data_ok}, 2'b00);
         end else begin
            check("starve_dok", {inst_data_ok, data_data_ok},
                  (((c - 1) / 2) % 4 == 3) ? 2'b10 : 2'b01);
         end
         advance();
      end

      // Reset during an inst transaction; its late response is ignored
      data_req = 0; bus_data_ok = 0;
      settle();
      check("rst_pre_iaok", inst_addr_ok, 1'b1);
      advance();
      rst = 1; inst_req = 0;
      settle();
      check("rst_ctrl", {bus_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 5'b0);
      advance();
      rst = 0; bus_data_ok = 1; bus_addr_ok = 0; data_req = 1; data_addr = 32'h0000_5000;
      settle();
      check("late_dok", {inst_data_ok, data_data_ok}, 2'b00);
      check("late_breq", bus_req, 1'b1);
      check("late_addr", bus_addr, 32'h0000_5000);
      advance();

      // Randomized traffic: caches hold requests until accepted, bus answers at random
      for (int n = 0; n < 3000; n++) begin
         bit i_acc, d_acc;
         rst = ($urandom_range(0, 299) == 0);
         if (!inst_req && $urandom_range(0, 2) == 0) begin
            inst_req = 1; inst_addr = $urandom; inst_wdata = $urandom;
            inst_wr = 1'($urandom_range(0, 1)); inst_size = 2'($urandom_range(0, 3));
         end
         if (!data_req && $urandom_range(0, 2) == 0) begin
            data_req = 1; data_addr = $urandom; data_wdata = $urandom;
            data_wr = 1'($urandom_range(0, 1)); data_size = 2'($urandom_range(0, 3));
         end
         bus_addr_ok = 1'($urandom_range(0, 1));
         bus_data_ok = ($urandom_range(0, 2) == 0);
         bus_rdata   = $urandom;
         settle();
         i_acc = e_iaok;
         d_acc = e_daok;
         advance();
         if (i_acc) inst_req = 0;
         if (d_acc) data_req = 0;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
